mem_port_arb: RTL and testbench
===============================

MEM_PORT_ARB -- requirements
Module: mem_port_arb

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the maximum number of cycles waiting for a memory response.
REQ-002 SHALL have parameter STARVE_MAX, default 4, meaning the number of consecutive fetch losses that forces a fetch grant.
REQ-003 SHALL use one clock and an asynchronous, active-low reset; ports in order:
- i_clk  in  1  clock
- i_rst_n  in  1  async active-low reset
- i_if_req  in  1  fetch request, held until o_if_vld
- i_if_addr  in  32  fetch address
- o_if_rdata  out  32  fetch data
- o_if_vld  out  1  fetch done pulse
- i_d_req  in  1  data request (load/store), held until o_d_vld
- i_d_wen  in  1  1 = store
- i_d_addr  in  32  data address
- i_d_wdata  in  32  store data
- i_d_mask  in  4  byte enables
- o_d_rdata  out  32  load data
- o_d_vld  out  1  data done pulse
- o_mem_req  out  1  memory request
- o_mem_addr  out  32  memory address
- o_mem_wen  out  1  memory write
- o_mem_wdata  out  32  memory write data
- o_mem_mask  out  4  memory byte enables
- i_mem_ready  in  1  memory accepts request
- i_mem_rvld  in  1  memory response valid
- i_mem_rdata  in  32  memory read data
- o_stall  out  1  core stall
- o_err  out  1  timeout pulse
- o_err_src  out  1  owner at timeout: 0 = fetch, 1 = data

Function
REQ-004 SHALL implement the FSM IDLE -> ISSUE -> RESP -> IDLE, with one outstanding transaction.
REQ-005 IDLE SHALL grant when any request is present: data wins over fetch unless the starvation count equals STARVE_MAX, in which case fetch wins. On grant, it latches the owner, addr, wen, wdata and mask, and moves to ISSUE.
REQ-006 Fetch grants SHALL always drive wen=0 and mask=4'hF.
REQ-007 ISSUE SHALL drive o_mem_req=1 with the latched fields, stable, until a cycle with i_mem_ready=1, then move to RESP. o_mem_req SHALL be 0 in all other states.
REQ-008 RESP SHALL, on i_mem_rvld, pulse the owner's vld for exactly 1 cycle, drive its rdata with i_mem_rdata in that same cycle, and return to IDLE. The non-owner's vld SHALL stay 0.
REQ-009 i_mem_rvld SHALL be ignored outside RESP, including in the cycle i_mem_ready is accepted (minimum memory latency is 1 cycle).
REQ-010 Stores SHALL complete through i_mem_rvld like loads. o_d_rdata is don't-care for stores but SHALL equal i_mem_rdata.
REQ-011 Starvation counter (3 bits, saturating at STARVE_MAX): increments when data is granted while i_if_req=1; clears on any fetch grant.
REQ-012 Timeout counter: clears on entering ISSUE and counts every cycle in ISSUE or RESP. On reaching TIMEOUT-1 without completion, the block SHALL pulse o_err=1 for 1 cycle with o_err_src=owner, pulse no vld, and return to IDLE.
REQ-013 Back-to-back operation: IDLE SHALL be re-entered for exactly 1 cycle between transactions, so request-to-vld latency is at least 3 cycles (grant, issue, resp).
REQ-014 o_stall SHALL equal (i_if_req & ~o_if_vld) | (i_d_req & ~o_d_vld), combinationally.
REQ-015 A request dropped before its vld is a requester protocol violation. The block SHALL complete the latched transaction regardless.
REQ-016 o_if_rdata and o_d_rdata SHALL hold their last delivered value when vld=0.

Reset
REQ-017 Asserting i_rst_n=0 SHALL immediately force state IDLE, both counters to 0, owner to fetch, and all outputs and latched fields to 0, regardless of the in-flight transaction.
REQ-018 After reset release, a response to an aborted transaction SHALL be ignored, because it arrives outside RESP.

Structure
REQ-019 The FSM state enum, owner encoding (OWN_IF=0, OWN_D=1) and default TIMEOUT/STARVE_MAX SHALL live in shared package core_pkg.
REQ-020 The timeout counter SHALL be a sub-module, wdog_cnt (clear, enable, terminal-count pulse).

Verification
REQ-021 Single fetch, addr 0x0000_0100, ready in the first ISSUE cycle, rvld 2 cycles later with 0x0000_0013: o_if_vld for 1 cycle with o_if_rdata=0x0000_0013.
REQ-022 Simultaneous fetch and store (addr 0x200, wdata 0xDEAD_BEEF, mask 4'b0011): memory sees the store first with wen=1 and mask 0011, then the fetch; o_d_vld occurs before o_if_vld.
REQ-023 Fetch held, data requested continuously: after 4 data grants the fifth grant goes to fetch, and the counter returns to 0.
REQ-024 i_mem_ready=1 but rvld never asserted, TIMEOUT=16, data owner: o_err pulses with o_err_src=1 and no vld; the FSM returns to IDLE and the next fetch completes normally.
REQ-025 Reset asserted in RESP, then rvld pulsed after release: no vld, outputs 0, state IDLE.
REQ-026 Stall check: o_stall=1 from request until the vld cycle, and 0 in the vld cycle itself.

Source files
------------

// File: rtl/core_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg
// Shared types and defaults for the memory port arbiter.
//   arb_state_e  : arbiter FSM states (IDLE -> ISSUE -> RESP -> IDLE)
//   owner_e      : which requester owns the outstanding transaction
//   mem_txn_t    : fields latched at grant time and replayed to memory
//   DEF_TIMEOUT / DEF_STARVE_MAX : default parameter values
//   starveNext() : saturating increment for the fetch starvation counter
// ---------------------------------------------------------------------------
package core_pkg;

    localparam int unsigned DEF_TIMEOUT    = 16;
    localparam int unsigned DEF_STARVE_MAX = 4;

    // Instruction fetches always read the whole word.
    localparam logic [3:0]  FETCH_MASK     = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    typedef struct packed {
        owner_e      owner;
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  mask;
    } mem_txn_t;

    // Increment that sticks at maxVal, so a long data burst cannot wrap the
    // counter back below the forcing threshold.
    function automatic logic [2:0] starveNext(input logic [2:0] cnt,
                                              input logic [2:0] maxVal);
        logic [2:0] result;
        if (cnt >= maxVal) begin
            result = maxVal;
        end else begin
            result = cnt + 3'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/wdog_cnt.sv
// ---------------------------------------------------------------------------
// wdog_cnt
// Watchdog counter for the outstanding memory transaction.
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset
//   clr_i   : synchronous clear (has priority over enable)
//   en_i    : count this cycle
//   tc_o    : terminal-count pulse, high while enabled and count == TERMINAL
// ---------------------------------------------------------------------------
module wdog_cnt #(
    parameter int unsigned TERMINAL = 15,
    parameter int unsigned WIDTH    = 5
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Clear wins so the count is zero in the first cycle after a grant even
    // though the enable is also asserted from that cycle on.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // The terminal value is decoded combinationally so the owner sees the
    // error in the very cycle the limit is reached.
    assign tc_o = en_i & (count_q == WIDTH'(TERMINAL));

endmodule

// File: rtl/mem_port_arb.sv
// ---------------------------------------------------------------------------
// mem_port_arb
// Arbitrates an instruction-fetch port and a load/store port onto a single
// memory port with one outstanding transaction.
//   i_clk, i_rst_n               : clock, asynchronous active-low reset
//   i_if_req/i_if_addr           : fetch request (held until o_if_vld)
//   o_if_rdata/o_if_vld          : fetch data and one-cycle done pulse
//   i_d_req/i_d_wen/i_d_addr/
//   i_d_wdata/i_d_mask           : data request (held until o_d_vld)
//   o_d_rdata/o_d_vld            : load data and one-cycle done pulse
//   o_mem_req/addr/wen/wdata/mask: memory request, held until i_mem_ready
//   i_mem_ready                  : memory accepts the request
//   i_mem_rvld/i_mem_rdata       : memory response
//   o_stall                      : core stall while any request is pending
//   o_err/o_err_src              : timeout pulse and owner at timeout
// ---------------------------------------------------------------------------
module mem_port_arb
    import core_pkg::*;
#(
    parameter int unsigned TIMEOUT    = DEF_TIMEOUT,
    parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    output logic [31:0] o_if_rdata,
    output logic        o_if_vld,
    input  logic        i_d_req,
    input  logic        i_d_wen,
    input  logic [31:0] i_d_addr,
    input  logic [31:0] i_d_wdata,
    input  logic [3:0]  i_d_mask,
    output logic [31:0] o_d_rdata,
    output logic        o_d_vld,
    output logic        o_mem_req,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_mask,
    input  logic        i_mem_ready,
    input  logic        i_mem_rvld,
    input  logic [31:0] i_mem_rdata,
    output logic        o_stall,
    output logic        o_err,
    output logic        o_err_src
);

    localparam int unsigned WDOG_W     = $clog2(TIMEOUT + 1);
    localparam logic [2:0]  STARVE_LIM = 3'(STARVE_MAX);

    arb_state_e  state_q;
    arb_state_e  state_d;
    mem_txn_t    txn_q;
    mem_txn_t    txn_d;
    logic [2:0]  starveCnt_q;
    logic [2:0]  starveCnt_d;
    logic [31:0] ifRdata_q;
    logic [31:0] ifRdata_d;
    logic [31:0] dRdata_q;
    logic [31:0] dRdata_d;

    logic        anyReq;
    logic        fetchWins;
    logic        grant;
    logic        respDone;
    logic        wdogEn;
    logic        wdogTc;
    logic        timeoutHit;
    logic        memReq;
    logic        ifVld;
    logic        dVld;
    logic        errPulse;

    assign anyReq    = i_if_req | i_d_req;

    // Data normally has priority; fetch takes the grant when it is the only
    // requester or once it has lost STARVE_MAX arbitrations in a row.
    assign fetchWins = i_if_req & (~i_d_req | (starveCnt_q == STARVE_LIM));

    assign grant     = (state_q == ST_IDLE) & anyReq;

    // A response only counts while waiting for it; a response in the accept
    // cycle or after a reset-aborted transaction is dropped.
    assign respDone  = (state_q == ST_RESP) & i_mem_rvld;

    assign wdogEn    = (state_q == ST_ISSUE) | (state_q == ST_RESP);

    wdog_cnt #(
        .TERMINAL (TIMEOUT - 1),
        .WIDTH    (WDOG_W)
    ) u_wdog (
        .clk_i  (i_clk),
        .rst_ni (i_rst_n),
        .clr_i  (grant),
        .en_i   (wdogEn),
        .tc_o   (wdogTc)
    );

    // A response arriving in the terminal cycle still completes normally.
    assign timeoutHit = wdogTc & ~respDone;

    // Next-state, grant latching and per-cycle pulses.
    always_comb begin
        state_d     = state_q;
        txn_d       = txn_q;
        starveCnt_d = starveCnt_q;
        memReq      = 1'b0;
        ifVld       = 1'b0;
        dVld        = 1'b0;
        errPulse    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (anyReq) begin
                    state_d = ST_ISSUE;
                    if (fetchWins) begin
                        txn_d.owner = OWN_IF;
                        txn_d.addr  = i_if_addr;
                        txn_d.wen   = 1'b0;
                        txn_d.wdata = 32'h0;
                        txn_d.mask  = FETCH_MASK;
                        starveCnt_d = 3'd0;
                    end else begin
                        txn_d.owner = OWN_D;
                        txn_d.addr  = i_d_addr;
                        txn_d.wen   = i_d_wen;
                        txn_d.wdata = i_d_wdata;
                        txn_d.mask  = i_d_mask;
                        if (i_if_req) begin
                            starveCnt_d = starveNext(starveCnt_q, STARVE_LIM);
                        end
                    end
                end
            end

            ST_ISSUE: begin
                memReq = 1'b1;
                if (timeoutHit) begin
                    errPulse = 1'b1;
                    state_d  = ST_IDLE;
                end else if (i_mem_ready) begin
                    state_d = ST_RESP;
                end
            end

            ST_RESP: begin
                if (respDone) begin
                    ifVld   = (txn_q.owner == OWN_IF);
                    dVld    = (txn_q.owner == OWN_D);
                    state_d = ST_IDLE;
                end else if (timeoutHit) begin
                    errPulse = 1'b1;
                    state_d  = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Read data is passed straight through in the done cycle and captured so
    // each port keeps showing its last delivered word afterwards.
    always_comb begin
        ifRdata_d = ifRdata_q;
        dRdata_d  = dRdata_q;
        if (ifVld) begin
            ifRdata_d = i_mem_rdata;
        end
        if (dVld) begin
            dRdata_d = i_mem_rdata;
        end
    end

    // State, latched transaction, starvation counter and read-data holding
    // registers; reset aborts whatever was in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            txn_q       <= '0;
            starveCnt_q <= 3'd0;
            ifRdata_q   <= 32'h0;
            dRdata_q    <= 32'h0;
        end else begin
            state_q     <= state_d;
            txn_q       <= txn_d;
            starveCnt_q <= starveCnt_d;
            ifRdata_q   <= ifRdata_d;
            dRdata_q    <= dRdata_d;
        end
    end

    assign o_mem_req   = memReq;
    assign o_mem_addr  = txn_q.addr;
    assign o_mem_wen   = txn_q.wen;
    assign o_mem_wdata = txn_q.wdata;
    assign o_mem_mask  = txn_q.mask;

    assign o_if_vld    = ifVld;
    assign o_d_vld     = dVld;
    assign o_if_rdata  = ifVld ? i_mem_rdata : ifRdata_q;
    assign o_d_rdata   = dVld  ? i_mem_rdata : dRdata_q;

    assign o_err       = errPulse;
    assign o_err_src   = txn_q.owner;

    // The stall drops in the done cycle itself so the core can advance on
    // the same edge that delivers its data.
    assign o_stall     = (i_if_req & ~ifVld) | (i_d_req & ~dVld);

endmodule

// File: tb/tb_mem_port_arb.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arb
// Directed bench for mem_port_arb. Expected memory transactions are queued
// when requests are driven and popped when the memory port issues them.
// Inputs change on the falling edge; outputs are sampled 1ns later.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_port_arb;
    import core_pkg::*;

    logic        clock = 1'b0;
    logic        rstN;
    logic        ifReq;
    logic [31:0] ifAddr;
    logic [31:0] ifRdata;
    logic        ifVld;
    logic        dReq;
    logic        dWen;
    logic [31:0] dAddr;
    logic [31:0] dWdata;
    logic [3:0]  dMask;
    logic [31:0] dRdata;
    logic        dVld;
    logic        memReq;
    logic [31:0] memAddr;
    logic        memWen;
    logic [31:0] memWdata;
    logic [3:0]  memMask;
    logic        memReady;
    logic        memRvld;
    logic [31:0] memRdataIn;
    logic        stall;
    logic        err;
    logic        errSrc;

    int          vectors     = 0;
    int          miscompares = 0;
    mem_txn_t    expQ[$];

    mem_port_arb #(
        .TIMEOUT    (16),
        .STARVE_MAX (4)
    ) dut (
        .i_clk       (clock),
        .i_rst_n     (rstN),
        .i_if_req    (ifReq),
        .i_if_addr   (ifAddr),
        .o_if_rdata  (ifRdata),
        .o_if_vld    (ifVld),
        .i_d_req     (dReq),
        .i_d_wen     (dWen),
        .i_d_addr    (dAddr),
        .i_d_wdata   (dWdata),
        .i_d_mask    (dMask),
        .o_d_rdata   (dRdata),
        .o_d_vld     (dVld),
        .o_mem_req   (memReq),
        .o_mem_addr  (memAddr),
        .o_mem_wen   (memWen),
        .o_mem_wdata (memWdata),
        .o_mem_mask  (memMask),
        .i_mem_ready (memReady),
        .i_mem_rvld  (memRvld),
        .i_mem_rdata (memRdataIn),
        .o_stall     (stall),
        .o_err       (err),
        .o_err_src   (errSrc)
    );

    // Free-running clock, 10ns period.
    always #5 clock = ~clock;

    // Hard stop in case something hangs outside the bounded waits.
    initial begin
        #100000;
        $display("[TB] FAIL globalTimeout observed=running required=finished");
        $fatal(1, "[TB] simulation time limit");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic fReq, input logic [31:0] fAddr,
                                 input logic rq, input logic wen,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] mask);
        @(negedge clock);
        ifReq  = fReq;
        ifAddr = fAddr;
        dReq   = rq;
        dWen   = wen;
        dAddr  = addr;
        dWdata = wdata;
        dMask  = mask;
    endtask

    task automatic expectTxn(input owner_e owner, input logic [31:0] addr,
                             input logic wen, input logic [31:0] wdata,
                             input logic [3:0] mask);
        mem_txn_t t;
        t.owner = owner;
        t.addr  = addr;
        t.wen   = wen;
        t.wdata = wdata;
        t.mask  = mask;
        expQ.push_back(t);
    endtask

    // Waits (bounded) for the memory request, pops the expected transaction
    // and checks the issued fields.
    task automatic checkIssue(output mem_txn_t exp, output bit ok);
        bit seen = 1'b0;
        ok  = 1'b0;
        exp = '0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clock);
            #1;
            if (memReq) seen = 1'b1;
        end
        if (!seen) begin
            checkOutput("memReqSeen", {31'd0, memReq}, 32'd1);
            return;
        end
        if (expQ.size() == 0) begin
            checkOutput("unexpectedIssue", memAddr, 32'hFFFF_FFFF);
            return;
        end
        exp = expQ.pop_front();
        checkOutput("memAddr", memAddr, exp.addr);
        checkOutput("memWen", {31'd0, memWen}, {31'd0, exp.wen});
        checkOutput("memMask", {28'd0, memMask}, {28'd0, exp.mask});
        if (exp.wen) checkOutput("memWdata", memWdata, exp.wdata);
        checkOutput("stallPending", {31'd0, stall}, 32'd1);
        ok = 1'b1;
    endtask

    // Plays the memory side for one transaction: ready after readyWait
    // cycles, response latency cycles after acceptance.
    task automatic serveMem(input int readyWait, input int latency,
                            input logic [31:0] rdata, input logic drop,
                            input logic spurious);
        mem_txn_t exp;
        bit       ok;
        logic     expIf;
        logic     expD;
        logic     expStall;
        checkIssue(exp, ok);
        if (!ok) return;
        for (int w = 0; w < readyWait; w++) begin
            @(negedge clock);
            #1;
            checkOutput("memReqHeld", {31'd0, memReq}, 32'd1);
            checkOutput("memAddrStable", memAddr, exp.addr);
        end
        memReady = 1'b1;
        if (spurious) begin
            memRvld    = 1'b1;
            memRdataIn = 32'hFFFF_0000;
        end
        #1;
        checkOutput("noVldInAccept", {30'd0, ifVld, dVld}, 32'd0);
        for (int l = 1; l <= latency; l++) begin
            @(negedge clock);
            memReady   = 1'b0;
            memRvld    = (l == latency);
            memRdataIn = (l == latency) ? rdata : 32'h5A5A_5A5A;
            #1;
            if (l == 1) checkOutput("memReqLowInResp", {31'd0, memReq}, 32'd0);
            if (l < latency) checkOutput("noVldWaiting", {30'd0, ifVld, dVld}, 32'd0);
        end
        expIf    = (exp.owner == OWN_IF);
        expD     = (exp.owner == OWN_D);
        expStall = (ifReq & ~expIf) | (dReq & ~expD);
        checkOutput("ifVld", {31'd0, ifVld}, {31'd0, expIf});
        checkOutput("dVld", {31'd0, dVld}, {31'd0, expD});
        checkOutput("rdata", expIf ? ifRdata : dRdata, rdata);
        checkOutput("stallAtVld", {31'd0, stall}, {31'd0, expStall});
        @(negedge clock);
        memRvld    = 1'b0;
        memRdataIn = ~rdata;
        if (drop) begin
            if (expIf) ifReq = 1'b0;
            else       dReq  = 1'b0;
        end
        #1;
        checkOutput("vldOneCycle", {30'd0, ifVld, dVld}, 32'd0);
        checkOutput("rdataHold", expIf ? ifRdata : dRdata, rdata);
    endtask

    initial begin
        mem_txn_t exp;
        bit       ok;
        int       errAt;
        bit       vldSeen;

        rstN       = 1'b0;
        ifReq      = 1'b0;
        ifAddr     = 32'h0;
        dReq       = 1'b0;
        dWen       = 1'b0;
        dAddr      = 32'h0;
        dWdata     = 32'h0;
        dMask      = 4'h0;
        memReady   = 1'b0;
        memRvld    = 1'b0;
        memRdataIn = 32'h0;

        // Reset state.
        #2;
        checkOutput("rstMemReq", {31'd0, memReq}, 32'd0);
        checkOutput("rstVld", {30'd0, ifVld, dVld}, 32'd0);
        checkOutput("rstErr", {30'd0, err, errSrc}, 32'd0);
        checkOutput("rstIfRdata", ifRdata, 32'h0);
        checkOutput("rstDRdata", dRdata, 32'h0);
        checkOutput("rstMemAddr", memAddr, 32'h0);
        repeat (2) @(negedge clock);
        rstN = 1'b1;
        $display("[TB] reset released");

        // Single fetch, spurious rvld in the accept cycle must be ignored.
        applyStimulus(1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        expectTxn(OWN_IF, 32'h0000_0100, 1'b0, 32'h0, 4'hF);
        serveMem(0, 2, 32'h0000_0013, 1'b1, 1'b1);

        // Simultaneous fetch and store: store goes first.
        applyStimulus(1'b1, 32'h0000_0300, 1'b1, 1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 4'b0011);
        expectTxn(OWN_D, 32'h0000_0200, 1'b1, 32'hDEAD_BEEF, 4'b0011);
        expectTxn(OWN_IF, 32'h0000_0300, 1'b0, 32'h0, 4'hF);
        serveMem(0, 1, 32'h1111_1111, 1'b1, 1'b0);
        serveMem(2, 1, 32'h2222_2222, 1'b1, 1'b0);

        // Starvation: four data grants, then fetch, then data again.
        applyStimulus(1'b1, 32'h0000_0400, 1'b1, 1'b0, 32'h0000_0500, 32'h0, 4'hF);
        for (int k = 0; k < 4; k++) expectTxn(OWN_D, 32'h0000_0500, 1'b0, 32'h0, 4'hF);
        expectTxn(OWN_IF, 32'h0000_0400, 1'b0, 32'h0, 4'hF);
        expectTxn(OWN_D, 32'h0000_0500, 1'b0, 32'h0, 4'hF);
        expectTxn(OWN_IF, 32'h0000_0400, 1'b0, 32'h0, 4'hF);
        for (int k = 0; k < 4; k++) serveMem(0, 1, 32'hA000_0000 + k, 1'b0, 1'b0);
        serveMem(0, 1, 32'hB000_0005, 1'b0, 1'b0);
        serveMem(0, 1, 32'hA000_0006, 1'b1, 1'b0);
        serveMem(0, 1, 32'hB000_0007, 1'b1, 1'b0);

        // Data load that never gets a response: timeout after 16 cycles.
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0600, 32'h0, 4'hF);
        expectTxn(OWN_D, 32'h0000_0600, 1'b0, 32'h0, 4'hF);
        checkIssue(exp, ok);
        memReady = 1'b1;
        errAt    = -1;
        vldSeen  = 1'b0;
        for (int i = 1; i <= 40 && errAt < 0; i++) begin
            @(negedge clock);
            memReady = 1'b0;
            #1;
            if (ifVld | dVld) vldSeen = 1'b1;
            if (err) begin
                errAt = i;
                checkOutput("errSrc", {31'd0, errSrc}, 32'd1);
            end
        end
        checkOutput("timeoutCycle", errAt, 32'd15);
        checkOutput("noVldOnTimeout", {31'd0, vldSeen}, 32'd0);
        @(negedge clock);
        dReq = 1'b0;
        #1;
        checkOutput("errOneCycle", {31'd0, err}, 32'd0);
        checkOutput("idleAfterErr", {31'd0, memReq}, 32'd0);

        applyStimulus(1'b1, 32'h0000_0800, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        expectTxn(OWN_IF, 32'h0000_0800, 1'b0, 32'h0, 4'hF);
        serveMem(0, 3, 32'h0000_0813, 1'b1, 1'b0);

        // Reset while waiting for the response; the late response is ignored.
        applyStimulus(1'b1, 32'h0000_0700, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        expectTxn(OWN_IF, 32'h0000_0700, 1'b0, 32'h0, 4'hF);
        checkIssue(exp, ok);
        memReady = 1'b1;
        @(negedge clock);
        memReady = 1'b0;
        #1;
        checkOutput("inRespBeforeRst", {31'd0, memReq}, 32'd0);
        #1;
        rstN  = 1'b0;
        ifReq = 1'b0;
        #1;
        checkOutput("rstMidMemReq", {31'd0, memReq}, 32'd0);
        checkOutput("rstMidMemAddr", memAddr, 32'h0);
        checkOutput("rstMidMemMask", {28'd0, memMask}, 32'd0);
        checkOutput("rstMidIfRdata", ifRdata, 32'h0);
        checkOutput("rstMidDRdata", dRdata, 32'h0);
        checkOutput("rstMidErr", {30'd0, err, errSrc}, 32'd0);
        @(negedge clock);
        rstN = 1'b1;
        @(negedge clock);
        memRvld    = 1'b1;
        memRdataIn = 32'hBAD0_0BAD;
        #1;
        checkOutput("lateRespVld", {30'd0, ifVld, dVld}, 32'd0);
        checkOutput("lateRespIfRdata", ifRdata, 32'h0);
        checkOutput("lateRespMemReq", {31'd0, memReq}, 32'd0);
        @(negedge clock);
        memRvld = 1'b0;

        applyStimulus(1'b1, 32'h0000_0900, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        expectTxn(OWN_IF, 32'h0000_0900, 1'b0, 32'h0, 4'hF);
        serveMem(1, 1, 32'h0000_0913, 1'b1, 1'b0);

        checkOutput("queueDrained", expQ.size(), 32'd0);
        repeat (2) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
